// File: rtl/mem_parity_reader.sv
// mem_parity_reader
//   Read-side initiator for a parity-protected RAM whose words are
//   {parity, data} with even parity held in the MSB. One request is taken
//   at a time: the address is latched, a single-cycle read strobe is sent
//   to the RAM, the returned word is captured and parity-checked, and the
//   result is offered on a valid/ready response port. A saturating counter
//   tracks how many parity errors have been seen.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  read request present
//   req_ready  block can accept a request (only while idle)
//   req_addr   address to read, sampled on the request handshake
//   mem_read   RAM read strobe, one cycle per request
//   mem_write  RAM write strobe, always 0 (this block never writes)
//   mem_addr   RAM address, holds its last value between reads
//   mem_rdata  RAM read word {parity, data}, registered by the RAM
//   rsp_valid  response present
//   rsp_ready  consumer accepts the response
//   rsp_data   raw data bits of the word read (also when parity is bad)
//   rsp_addr   address the response belongs to
//   rsp_perr   1 when the word failed the even-parity check
//   clr_err    synchronous clear of err_count
//   err_count  saturating count of parity errors

module mem_parity_reader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W:0]      mem_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic [ADDR_W-1:0]    rsp_addr,
  output logic                 rsp_perr,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_perr_q, rsp_perr_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic perr;
  logic err_inc;

  // Even parity: the stored parity bit must equal the XOR of the data bits.
  assign perr    = mem_rdata[DATA_W] ^ (^mem_rdata[DATA_W-1:0]);
  assign err_inc = (state_q == CAPTURE) && perr;

  // Handshake and strobe outputs decode straight from the state register,
  // so an asynchronous reset drops mem_read and rsp_valid at once without
  // waiting for a clock edge. addr_q doubles as the RAM address; it only
  // changes on the request handshake, so it holds between reads.
  assign req_ready = (state_q == IDLE);
  assign mem_read  = (state_q == ISSUE);
  assign mem_write = 1'b0;
  assign mem_addr  = addr_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_perr  = rsp_perr_q;
  assign err_count = err_count_q;

  // Next-state and datapath logic. The response registers are loaded only
  // on the capture edge, which keeps them stable for as long as the
  // consumer stalls in RESP. Request addresses arriving outside IDLE are
  // ignored because the address is only taken in IDLE.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_perr_d = rsp_perr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d = mem_rdata[DATA_W-1:0];
        rsp_perr_d = perr;
        rsp_addr_d = addr_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Error counter. A clear that coincides with a fresh error leaves the
  // count at one so that error is not lost; otherwise it counts up and
  // sticks at all-ones instead of wrapping.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = err_inc ? CNT_ONE : '0;
    end else if (err_inc && !(&err_count_q)) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  // State and datapath registers, all cleared asynchronously so a reset in
  // any state abandons the transaction and drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_perr_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_perr_q  <= rsp_perr_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_mem_parity_reader.sv
// tb_mem_parity_reader
//   Directed bench for mem_parity_reader with a small registered RAM model.
//   The error counter is built 4 bits wide so saturation is reachable.

module tb_mem_parity_reader;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [8:0]  mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_perr;
  logic        clr_err;
  logic [3:0]  err_count;

  int total;
  int bad;

  logic [8:0] ram  [logic [15:0]];
  logic [7:0] gold [logic [15:0]];

  mem_parity_reader #(
    .ADDR_W   (16),
    .DATA_W   (8),
    .ERR_CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_addr (rsp_addr),
    .rsp_perr (rsp_perr),
    .clr_err  (clr_err),
    .err_count(err_count)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registers the addressed word on the edge that ends the read strobe.
  always @(posedge clk) begin
    if (mem_read) begin
      mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 9'h000;
    end
  end

  // Hard stop in case some wait escapes its bound.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hands a request to the DUT and waits until the response is presented.
  // Reports how many read strobes were seen and how many edges it took.
  task automatic applyStimulus(input logic [15:0] a, output int pulses, output int lat);
    int n;
    pulses = 0;
    lat    = 0;
    n      = 0;
    req_addr  = a;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr  = ~a;
    n = 0;
    while (!rsp_valid && n < 50) begin
      if (mem_read) pulses++;
      tick();
      n++;
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
  endtask

  function automatic logic [8:0] good_word(input logic [7:0] d);
    return {^d, d};
  endfunction

  logic [15:0] addrs [100];
  int pulses;
  int lat;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0000;
    rsp_ready = 1'b1;
    clr_err   = 1'b0;

    ram[16'h00A5] = 9'h03C;
    ram[16'h1234] = 9'h13C;

    // Reset values
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mem_read",  32'(mem_read),  32'd0);
    checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst_mem_addr",  32'(mem_addr),  32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data",  32'(rsp_data),  32'd0);
    checkOutput("rst_rsp_addr",  32'(rsp_addr),  32'd0);
    checkOutput("rst_rsp_perr",  32'(rsp_perr),  32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Good-parity read
    applyStimulus(16'h00A5, pulses, lat);
    checkOutput("t1_latency",   32'(lat),       32'd2);
    checkOutput("t1_pulses",    32'(pulses),    32'd1);
    checkOutput("t1_data",      32'(rsp_data),  32'h3C);
    checkOutput("t1_perr",      32'(rsp_perr),  32'd0);
    checkOutput("t1_addr",      32'(rsp_addr),  32'h00A5);
    checkOutput("t1_err_count", 32'(err_count), 32'd0);
    checkOutput("t1_mem_addr",  32'(mem_addr),  32'h00A5);
    tick();
    checkOutput("t1_rsp_done",  32'(rsp_valid), 32'd0);

    // Bad-parity read returns raw data with the error flag
    applyStimulus(16'h1234, pulses, lat);
    checkOutput("t2_data",      32'(rsp_data),  32'h3C);
    checkOutput("t2_perr",      32'(rsp_perr),  32'd1);
    checkOutput("t2_addr",      32'(rsp_addr),  32'h1234);
    checkOutput("t2_err_count", 32'(err_count), 32'd1);
    tick();

    // Consumer stall: response held, new requests ignored
    rsp_ready = 1'b0;
    applyStimulus(16'h00A5, pulses, lat);
    req_valid = 1'b1;
    req_addr  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t3_valid",     32'(rsp_valid), 32'd1);
      checkOutput("t3_data",      32'(rsp_data),  32'h3C);
      checkOutput("t3_addr",      32'(rsp_addr),  32'h00A5);
      checkOutput("t3_perr",      32'(rsp_perr),  32'd0);
      checkOutput("t3_req_ready", 32'(req_ready), 32'd0);
      checkOutput("t3_mem_read",  32'(mem_read),  32'd0);
      checkOutput("t3_mem_addr",  32'(mem_addr),  32'h00A5);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checkOutput("t3_rsp_drop",  32'(rsp_valid), 32'd0);
    checkOutput("t3_req_ready", 32'(req_ready), 32'd1);

    // 100 random good words read back-to-back
    for (int i = 0; i < 100; i++) begin
      logic [7:0]  d;
      logic [15:0] a;
      a = 16'($urandom_range(16'h2000, 16'hFFFF));
      d = 8'($urandom_range(0, 255));
      addrs[i] = a;
      gold[a]  = d;
      ram[a]   = good_word(d);
    end
    for (int i = 0; i < 100; i++) begin
      applyStimulus(addrs[i], pulses, lat);
      checkOutput("t4_data",   32'(rsp_data), 32'(gold[addrs[i]]));
      checkOutput("t4_addr",   32'(rsp_addr), 32'(addrs[i]));
      checkOutput("t4_perr",   32'(rsp_perr), 32'd0);
      checkOutput("t4_pulses", 32'(pulses),   32'd1);
      tick();
    end
    checkOutput("t4_err_count", 32'(err_count), 32'd1);

    // Counter clear, saturation, and clear racing a new error
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("t5_cleared", 32'(err_count), 32'd0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(16'h1234, pulses, lat);
      tick();
    end
    checkOutput("t5_at_max", 32'(err_count), 32'hF);
    applyStimulus(16'h1234, pulses, lat);
    tick();
    checkOutput("t5_saturate", 32'(err_count), 32'hF);
    req_addr  = 16'h1234;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("t5_clr_and_err", 32'(err_count), 32'd1);
    checkOutput("t5_rsp_valid",   32'(rsp_valid), 32'd1);
    checkOutput("t5_rsp_perr",    32'(rsp_perr),  32'd1);
    tick();

    // Reset while the read strobe is up
    req_addr  = 16'h00A5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("t6_in_issue", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6a_mem_read",  32'(mem_read),  32'd0);
    checkOutput("t6a_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t6a_err_count", 32'(err_count), 32'd0);
    checkOutput("t6a_req_ready", 32'(req_ready), 32'd1);
    checkOutput("t6a_mem_addr",  32'(mem_addr),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset while a response is pending
    rsp_ready = 1'b0;
    applyStimulus(16'h1234, pulses, lat);
    checkOutput("t6_pre_err", 32'(err_count), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6b_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("t6b_mem_read",  32'(mem_read),  32'd0);
    checkOutput("t6b_err_count", 32'(err_count), 32'd0);
    checkOutput("t6b_rsp_data",  32'(rsp_data),  32'd0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // Normal read after reset
    applyStimulus(16'h00A5, pulses, lat);
    checkOutput("t6c_data",   32'(rsp_data), 32'h3C);
    checkOutput("t6c_addr",   32'(rsp_addr), 32'h00A5);
    checkOutput("t6c_perr",   32'(rsp_perr), 32'd0);
    checkOutput("t6c_pulses", 32'(pulses),   32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
